seq_shift_add_multiplier: RTL and testbench

//  Parametrised sequential shift-add multiplier: one partial product accumulated per clock.

---
 rtl/seq_shift_add_multiplier.sv | 108 ++++++++++
 tb/tb_seq_shift_add_multiplier.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_shift_add_multiplier.sv
// Sequential shift-add multiplier. Each COMPUTE cycle adds one partial product,
// and the operands can be unsigned or two's-complement signed.
module seq_shift_add_multiplier #(
   parameter int unsigned WIDTH = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start_i,
   input  logic                 signed_i,
   input  logic [WIDTH-1:0]     a_i,
   input  logic [WIDTH-1:0]     b_i,
   output logic [2*WIDTH-1:0]   y_o,
   output logic                 busy_o,
   output logic                 done_o,
   output logic [1:0]           state_o
);

   localparam int unsigned PW    = 2 * WIDTH;
   localparam int unsigned CNT_W = $clog2(WIDTH);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COMPUTE = 2'd1,
      FINISH  = 2'd2
   } state_t;

   state_t             state_r, state_n;
   logic [WIDTH-1:0]   mag_a_r, mag_a_n;
   logic [WIDTH-1:0]   mag_b_r, mag_b_n;
   logic [PW-1:0]      acc_r, acc_n;
   logic [CNT_W-1:0]   cnt_r, cnt_n;
   logic               neg_r, neg_n;
   logic [PW-1:0]      y_n;
   logic               busy_n;
   logic               done_n;

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
         mag_a_r <= '0;
         mag_b_r <= '0;
         acc_r   <= '0;
         cnt_r   <= '0;
         neg_r   <= 1'b0;
         y_o     <= '0;
         busy_o  <= 1'b0;
         done_o  <= 1'b0;
      end else begin
         state_r <= state_n;
         mag_a_r <= mag_a_n;
         mag_b_r <= mag_b_n;
         acc_r   <= acc_n;
         cnt_r   <= cnt_n;
         neg_r   <= neg_n;
         y_o     <= y_n;
         busy_o  <= busy_n;
         done_o  <= done_n;
      end
   end

   // Next-state and next-output logic; the sign is applied only once, in FINISH
   always_comb begin
      state_n = state_r;
      mag_a_n = mag_a_r;
      mag_b_n = mag_b_r;
      acc_n   = acc_r;
      cnt_n   = cnt_r;
      neg_n   = neg_r;
      y_n     = y_o;
      done_n  = 1'b0;

      case (state_r)
         IDLE: begin
            if (start_i) begin
               mag_a_n = (signed_i && a_i[WIDTH-1]) ? (~a_i + WIDTH'(1)) : a_i;
               mag_b_n = (signed_i && b_i[WIDTH-1]) ? (~b_i + WIDTH'(1)) : b_i;
               neg_n   = signed_i & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
               acc_n   = '0;
               cnt_n   = '0;
               state_n = COMPUTE;
            end
         end
         COMPUTE: begin
            if (mag_b_r[cnt_r]) begin
               acc_n = acc_r + (PW'(mag_a_r) << cnt_r);
            end
            cnt_n = cnt_r + CNT_W'(1);
            if (cnt_r == CNT_W'(WIDTH - 1)) begin
               state_n = FINISH;
            end
         end
         FINISH: begin
            y_n     = neg_r ? (~acc_r + PW'(1)) : acc_r;
            done_n  = 1'b1;
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase

      busy_n = (state_n == COMPUTE) || (state_n == FINISH);
   end

   assign state_o = state_r;

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Self-checking bench for seq_shift_add_multiplier. It uses a 4-bit and an 8-bit
// instance and checks both against an arithmetic product model.
module tb_seq_shift_add_multiplier;

   logic        clk = 1'b0;
   logic        rst;
   logic        start4, sgn4, start8, sgn8;
   logic [3:0]  a4, b4;
   logic [7:0]  a8, b8;
   logic [7:0]  y4;
   logic [15:0] y8;
   logic        busy4, done4, busy8, done8;
   logic [1:0]  state4, state8;

   int vectors    = 0;
   int miscompares = 0;

   bit          w8_sel = 1'b0;
   logic [15:0] y_sel;
   logic        busy_sel, done_sel;

   typedef struct {
      bit          w8;
      logic [7:0]  a;
      logic [7:0]  b;
      bit          sgn;
      logic [15:0] y;
   } vec_t;

   vec_t tbl [12];

   seq_shift_add_multiplier #(.WIDTH(4)) dut4 (
      .clk(clk), .rst(rst), .start_i(start4), .signed_i(sgn4), .a_i(a4), .b_i(b4),
      .y_o(y4), .busy_o(busy4), .done_o(done4), .state_o(state4)
   );

   seq_shift_add_multiplier #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .start_i(start8), .signed_i(sgn8), .a_i(a8), .b_i(b8),
      .y_o(y8), .busy_o(busy8), .done_o(done8), .state_o(state8)
   );

   always #5 clk = ~clk;

   assign y_sel    = w8_sel ? y8 : {8'h00, y4};
   assign busy_sel = w8_sel ? busy8 : busy4;
   assign done_sel = w8_sel ? done8 : done4;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference product: interpret the operands at width w and take the low 2*w bits.
   function automatic logic [15:0] model(input bit w8, input logic [7:0] a,
                                         input logic [7:0] b, input bit sgn);
      int w;
      int sa;
      int sb;
      int p;
      w  = w8 ? 8 : 4;
      sa = int'(a);
      sb = int'(b);
      if (sgn && a[w-1]) sa = sa - (1 << w);
      if (sgn && b[w-1]) sb = sb - (1 << w);
      p = sa * sb;
      return w8 ? 16'(p) : {8'h00, 8'(p)};
   endfunction

   task automatic run_op(input bit w8, input logic [7:0] a, input logic [7:0] b,
                         input bit sgn, input logic [15:0] exp, input string name);
      int n;
      logic [15:0] y_done;
      w8_sel = w8;
      if (w8) begin
         a8 = a; b8 = b; sgn8 = sgn; start8 = 1'b1;
      end else begin
         a4 = a[3:0]; b4 = b[3:0]; sgn4 = sgn; start4 = 1'b1;
      end
      tick();
      start4 = 1'b0;
      start8 = 1'b0;
      check({name, " busy"}, 16'(busy_sel), 16'd1);
      n = 1;
      tick();
      while (!done_sel && n < 20) begin
         n++;
         tick();
      end
      check({name, " latency"}, 16'(n), w8 ? 16'd9 : 16'd5);
      check({name, " y"}, y_sel, exp);
      check({name, " idle at done"}, 16'(busy_sel), 16'd0);
      y_done = y_sel;
      tick();
      check({name, " done one cycle"}, 16'(done_sel), 16'd0);
      check({name, " y held"}, y_sel, y_done);
   endtask

   initial begin
      int n;
      int dones;
      logic [7:0]  ra, rb;
      bit          rs, rw;

      tbl[0]  = '{1'b0, 8'h0F, 8'h0F, 1'b0, 16'h00E1};
      tbl[1]  = '{1'b0, 8'h08, 8'h07, 1'b1, 16'h00C8};
      tbl[2]  = '{1'b0, 8'h08, 8'h08, 1'b1, 16'h0040};
      tbl[3]  = '{1'b0, 8'h0D, 8'h02, 1'b1, 16'h00FA};
      tbl[4]  = '{1'b0, 8'h00, 8'h08, 1'b1, 16'h0000};
      tbl[5]  = '{1'b0, 8'h08, 8'h07, 1'b0, 16'h0038};
      tbl[6]  = '{1'b0, 8'h0F, 8'h0F, 1'b1, 16'h0001};
      tbl[7]  = '{1'b0, 8'h07, 8'h0F, 1'b1, 16'h00F9};
      tbl[8]  = '{1'b1, 8'hFF, 8'hFF, 1'b0, 16'hFE01};
      tbl[9]  = '{1'b1, 8'h80, 8'h80, 1'b1, 16'h4000};
      tbl[10] = '{1'b1, 8'hFF, 8'h00, 1'b1, 16'h0000};
      tbl[11] = '{1'b1, 8'h80, 8'h7F, 1'b1, 16'hC080};

      rst = 1'b1;
      start4 = 1'b0; sgn4 = 1'b0; a4 = '0; b4 = '0;
      start8 = 1'b0; sgn8 = 1'b0; a8 = '0; b8 = '0;
      tick();
      tick();
      check("reset state4", 16'(state4), 16'd0);
      check("reset y4", 16'(y4), 16'd0);
      check("reset busy4", 16'(busy4), 16'd0);
      check("reset done4", 16'(done4), 16'd0);
      check("reset y8", y8, 16'd0);
      check("reset state8", 16'(state8), 16'd0);
      rst = 1'b0;
      tick();

      for (int i = 0; i < 12; i++) begin
         run_op(tbl[i].w8, tbl[i].a, tbl[i].b, tbl[i].sgn, tbl[i].y, $sformatf("tbl%0d", i));
      end

      for (int i = 0; i < 40; i++) begin
         rw = 1'($urandom_range(0, 1));
         rs = 1'($urandom_range(0, 1));
         ra = rw ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 15));
         rb = rw ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 15));
         run_op(rw, ra, rb, rs, model(rw, ra, rb, rs), $sformatf("rnd%0d", i));
      end

      // start held high: one accept per done cycle, mid-op operand changes ignored
      w8_sel = 1'b0;
      a4 = 4'h3; b4 = 4'h5; sgn4 = 1'b0; start4 = 1'b1;
      tick();
      dones = 0;
      for (int t = 1; t <= 17; t++) begin
         tick();
         if (t % 6 == 2) begin a4 = 4'hF; b4 = 4'hF; end
         if (t % 6 == 4) begin a4 = 4'h3; b4 = 4'h5; end
         check($sformatf("held start done t%0d", t), 16'(done4), (t % 6 == 5) ? 16'd1 : 16'd0);
         if (done4) begin
            dones++;
            check($sformatf("held start y t%0d", t), 16'(y4), 16'h000F);
         end
      end
      start4 = 1'b0;
      check("held start done count", 16'(dones), 16'd3);
      tick();
      check("held start idle", 16'(busy4), 16'd0);

      // reset in the third COMPUTE cycle aborts with no done pulse
      a4 = 4'hF; b4 = 4'hF; start4 = 1'b1;
      tick();
      start4 = 1'b0;
      tick();
      tick();
      check("abort state before rst", 16'(state4), 16'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("abort state", 16'(state4), 16'd0);
      check("abort y", 16'(y4), 16'd0);
      check("abort busy", 16'(busy4), 16'd0);
      dones = 0;
      for (int t = 0; t < 8; t++) begin
         if (done4) dones++;
         tick();
      end
      check("abort no done", 16'(dones), 16'd0);

      // back-to-back: second start issued in the done cycle of the first
      a4 = 4'h3; b4 = 4'h5; sgn4 = 1'b0; start4 = 1'b1;
      tick();
      start4 = 1'b0;
      n = 0;
      while (!done4 && n < 20) begin
         n++;
         tick();
      end
      check("b2b first y", 16'(y4), 16'h000F);
      a4 = 4'hD; b4 = 4'h2; sgn4 = 1'b1; start4 = 1'b1;
      tick();
      start4 = 1'b0;
      n = 1;
      tick();
      while (!done4 && n < 20) begin
         n++;
         tick();
      end
      check("b2b second latency", 16'(n), 16'd5);
      check("b2b second y", 16'(y4), 16'h00FA);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
